// File: rtl/axil_regbank_gen_if.sv
// AXI4-Lite bus bundle for the register bank; the slave modport is the bank side.
interface axil_regbank_gen_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_regbank_gen.sv
// Parametrised AXI4-Lite register bank with read-only, self-clearing and
// plain read/write registers, byte strobes and SLVERR for unmapped words.
module axil_regbank_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 8,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]            SC_MASK   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_regbank_gen_if.slave              s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(NB);
  localparam int IDX_W    = ADDR_WIDTH - BYTE_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  w_hit, r_hit, w_hs, r_hs;

  assign w_idx = s_axi.awaddr[ADDR_WIDTH-1:BYTE_LSB];
  assign r_idx = s_axi.araddr[ADDR_WIDTH-1:BYTE_LSB];
  assign w_hit = int'(w_idx) < NUM_REGS;
  assign r_hit = int'(r_idx) < NUM_REGS;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[BYTE_LSB-1:0], s_axi.araddr[BYTE_LSB-1:0]};

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; this is what makes a same-edge read return the old data.
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    w_next        = w_state;
    r_next        = r_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.bvalid  = (w_state == W_RESP);
    s_axi.rvalid  = (r_state == R_DATA);
    unique case (w_state)
      W_IDLE: if (s_axi.awvalid && s_axi.wvalid) begin
        s_axi.awready = 1'b1;
        s_axi.wready  = 1'b1;
        w_next        = W_RESP;
      end
      W_RESP: if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    unique case (r_state)
      R_IDLE: if (s_axi.arvalid) begin
        s_axi.arready = 1'b1;
        r_next        = R_DATA;
      end
      R_DATA: if (s_axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign w_hs = s_axi.awready;
  assign r_hs = s_axi.arready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi.bresp <= RESP_OKAY;
      s_axi.rresp <= RESP_OKAY;
      s_axi.rdata <= '0;
      wr_pulse    <= '0;
      // NOTE: the register array is a handful of flops, not a RAM, so it is
      // reset to RESET_VAL like any other control state.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_pulse <= '0;
      // Self-clearing registers drop to zero unless written on this edge.
      for (int i = 0; i < NUM_REGS; i++) if (SC_MASK[i]) regs[i] <= '0;
      if (w_hs) begin
        s_axi.bresp <= w_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_idx == IDX_W'(i) && !RO_MASK[i]) begin
            wr_pulse[i] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (s_axi.wstrb[b]) regs[i][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
          end
        end
      end
      if (r_hs) begin
        s_axi.rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
        s_axi.rdata <= '0;
        for (int i = 0; i < NUM_REGS; i++)
          if (r_idx == IDX_W'(i))
            s_axi.rdata <= RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_axil_regbank_gen.sv
// Directed bench for axil_regbank_gen: 8 x 32-bit regs, reg3 read-only, reg0 self-clearing.
module tb_axil_regbank_gen;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h5555AAAA, 32'h0,
                                     32'h00000033, 32'h0, 32'h0, 32'h0};
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in = '0;
  logic [NR-1:0]    wr_pulse;
  int checks = 0;
  int errors = 0;

  axil_regbank_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_regbank_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RESET_VAL(RV), .RO_MASK(8'h08), .SC_MASK(8'h01)
  ) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(bus.slave),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NR-1:0] pulse_hs, output logic [NR-1:0] pulse_after,
                           output logic [NR*DW-1:0] out_hs, output logic [NR*DW-1:0] out_after);
    bit ok;
    @(negedge clk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.awready && bus.wready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_handshake addr=%h: AWREADY/WREADY never high, required within 20 cycles", addr);
    end
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    pulse_hs = wr_pulse; out_hs = reg_out; resp = bus.bresp;
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_bvalid addr=%h: got %b, required 1", addr, bus.bvalid);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    pulse_after = wr_pulse; out_after = reg_out;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_bvalid_drop addr=%h: got %b, required 0", addr, bus.bvalid);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit ok;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_handshake addr=%h: ARREADY never high, required within 20 cycles", addr);
    end
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_rvalid addr=%h: got %b, required 1", addr, bus.rvalid);
    end
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: aw/w/ar/b/r = %b, required 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    checks++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h, required 0", bus.bresp, bus.rresp, bus.rdata);
    end
    checks++;
    if (reg_out !== RV || wr_pulse !== '0) begin
      errors++;
      $display("FAIL reset_regs: reg_out=%h wr_pulse=%b, required %h / 0", reg_out, wr_pulse, RV);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read_all();
    logic [1:0] resp; logic [NR-1:0] p1, p2; logic [NR*DW-1:0] o1, o2;
    logic [DW-1:0] rd, exp_rd; logic [NR-1:0] exp_p;
    for (int i = 0; i < NR; i++) begin
      axi_write(AW'(4 * i), DW'(i + 1), 4'hF, resp, p1, p2, o1, o2);
      exp_p = (i == 3) ? 8'h00 : (8'h01 << i);
      checks++;
      if (resp !== OKAY || p1 !== exp_p || p2 !== 8'h00) begin
        errors++;
        $display("FAIL wr_all reg%0d: bresp=%b pulse=%b next=%b, required 00 %b 00000000", i, resp, p1, p2, exp_p);
      end
      if (i != 3) begin
        checks++;
        if (o1[i*DW +: DW] !== DW'(i + 1)) begin
          errors++;
          $display("FAIL wr_all_out reg%0d: got %h, required %h", i, o1[i*DW +: DW], i + 1);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      axi_read(AW'(4 * i), rd, resp);
      exp_rd = (i == 0) ? 32'h0 : (i == 3) ? 32'hDEADBEEF : DW'(i + 1);
      checks++;
      if (rd !== exp_rd || resp !== OKAY) begin
        errors++;
        $display("FAIL rd_all reg%0d: rdata=%h rresp=%b, required %h 00", i, rd, resp, exp_rd);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [NR-1:0] p1, p2; logic [NR*DW-1:0] o1, o2; logic [DW-1:0] rd;
    axi_write(6'h08, 32'hAABBCCDD, 4'hF, resp, p1, p2, o1, o2);
    axi_write(6'h08, 32'h11223344, 4'b0101, resp, p1, p2, o1, o2);
    axi_read(6'h08, rd, resp);
    checks++;
    if (rd !== 32'hAA22CC44 || resp !== OKAY) begin
      errors++;
      $display("FAIL strobe_read: rdata=%h rresp=%b, required aa22cc44 00", rd, resp);
    end
    axi_read(6'h0B, rd, resp);
    checks++;
    if (rd !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL unaligned_read 0x0b: rdata=%h, required aa22cc44", rd);
    end
    axi_write(6'h09, 32'h000000EE, 4'b0001, resp, p1, p2, o1, o2);
    checks++;
    if (o1[2*DW +: DW] !== 32'hAA22CCEE || p1 !== 8'h04) begin
      errors++;
      $display("FAIL unaligned_write 0x09: reg2=%h pulse=%b, required aa22ccee 00000100", o1[2*DW +: DW], p1);
    end
  endtask

  task automatic test_ro();
    logic [1:0] resp; logic [NR-1:0] p1, p2; logic [NR*DW-1:0] o1, o2; logic [DW-1:0] rd;
    axi_write(6'h0C, 32'h0, 4'hF, resp, p1, p2, o1, o2);
    checks++;
    if (resp !== OKAY || p1 !== 8'h00 || o1[3*DW +: DW] !== 32'h33) begin
      errors++;
      $display("FAIL ro_write: bresp=%b pulse=%b reg3=%h, required 00 00000000 00000033", resp, p1, o1[3*DW +: DW]);
    end
    axi_read(6'h0C, rd, resp);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ro_read: rdata=%h, required deadbeef", rd);
    end
    reg_in[3*DW +: DW] = 32'h12345678;
    axi_read(6'h0C, rd, resp);
    checks++;
    if (rd !== 32'h12345678 || resp !== OKAY) begin
      errors++;
      $display("FAIL ro_read_live: rdata=%h rresp=%b, required 12345678 00", rd, resp);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [NR-1:0] p1, p2; logic [NR*DW-1:0] o1, o2, snap; logic [DW-1:0] rd;
    @(negedge clk);
    snap = reg_out;
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, resp, p1, p2, o1, o2);
    checks++;
    if (resp !== SLVERR || p1 !== 8'h00 || o1 !== snap || o2 !== snap) begin
      errors++;
      $display("FAIL slverr_write: bresp=%b pulse=%b reg_out=%h, required 10 00000000 %h", resp, p1, o1, snap);
    end
    axi_read(6'h20, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== SLVERR) begin
      errors++;
      $display("FAIL slverr_read 0x20: rdata=%h rresp=%b, required 0 10", rd, resp);
    end
    axi_read(6'h3C, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== SLVERR) begin
      errors++;
      $display("FAIL slverr_read 0x3c: rdata=%h rresp=%b, required 0 10", rd, resp);
    end
  endtask

  task automatic test_sc();
    logic [1:0] resp; logic [NR-1:0] p1, p2; logic [NR*DW-1:0] o1, o2; logic [DW-1:0] rd;
    axi_write(6'h00, 32'h5, 4'hF, resp, p1, p2, o1, o2);
    checks++;
    if (o1[0 +: DW] !== 32'h5 || o2[0 +: DW] !== 32'h0 || p1 !== 8'h01) begin
      errors++;
      $display("FAIL sc_pulse: reg0=%h then %h pulse=%b, required 5 then 0, 00000001", o1[0 +: DW], o2[0 +: DW], p1);
    end
    axi_read(6'h00, rd, resp);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL sc_read: rdata=%h, required 0", rd);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] resp; logic [DW-1:0] rd;
    @(negedge clk);
    bus.araddr = 6'h04; bus.arvalid = 1'b1;
    bus.awaddr = 6'h04; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    checks++;
    if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin
      errors++;
      $display("FAIL simul_ready: ar/aw/w=%b, required 111", {bus.arready, bus.awready, bus.wready});
    end
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h2 || bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL simul_old: rvalid=%b rdata=%h bvalid=%b, required 1 00000002 1", bus.rvalid, bus.rdata, bus.bvalid);
    end
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(6'h04, rd, resp);
    checks++;
    if (rd !== 32'h77) begin
      errors++;
      $display("FAIL simul_new: rdata=%h, required 77", rd);
    end
  endtask

  task automatic test_back_to_back();
    bit stable;
    @(negedge clk);
    bus.awaddr = 6'h10; bus.wdata = 32'hA5A5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ready: awready=%b, required 1", bus.awready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.awaddr = 6'h18; bus.wdata = 32'h5A5A;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.bvalid !== 1'b1 || bus.bresp !== OKAY || bus.awready !== 1'b0 || bus.wready !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL b2b_hold: bvalid/bresp not stable or second write accepted, got bvalid=%b bresp=%b awready=%b, required 1 00 0",
               bus.bvalid, bus.bresp, bus.awready);
    end
    bus.bready = 1'b1;
    #1;
    checks++;
    if (bus.awready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bready_cycle: awready=%b, required 0", bus.awready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    #1;
    checks++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next_accept: awready=%b wready=%b, required 1 1", bus.awready, bus.wready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (reg_out[4*DW +: DW] !== 32'hA5A5 || reg_out[6*DW +: DW] !== 32'h5A5A) begin
      errors++;
      $display("FAIL b2b_data: reg4=%h reg6=%h, required 0000a5a5 00005a5a", reg_out[4*DW +: DW], reg_out[6*DW +: DW]);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.awaddr = 6'h1C; bus.wdata = 32'h99; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: bvalid=%b, required 1", bus.bvalid);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.bvalid !== 1'b0 || reg_out !== RV || wr_pulse !== '0) begin
      errors++;
      $display("FAIL rstmid_post: bvalid=%b reg_out=%h wr_pulse=%b, required 0 %h 0", bus.bvalid, reg_out, wr_pulse, RV);
    end
    rst = 1'b0;
    bus.bready = 1'b1;
    repeat (2) @(negedge clk);
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_noresp: bvalid=%b, required 0", bus.bvalid);
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    reg_in[3*DW +: DW] = 32'hDEADBEEF;
    test_reset();
    test_write_read_all();
    test_strobe();
    test_ro();
    test_slverr();
    test_sc();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
